// File: rtl/joy_sega_if.sv
// Signals between the Sega pad reader, the pad connectors and the console core.
// One instance carries every port of one reader.
interface joy_sega_if #(
  parameter int unsigned CH = 2
);
  logic [6*CH-1:0]  pad_d;
  logic [CH-1:0]    pad_sel;
  logic [12*CH-1:0] joy;
  logic [CH-1:0]    six_btn;
  logic [CH-1:0]    present;
  logic             scan_done;

  modport master (
    input  pad_d,
    output pad_sel, joy, six_btn, present, scan_done
  );

  modport slave (
    output pad_d,
    input  pad_sel, joy, six_btn, present, scan_done
  );
endinterface

// File: rtl/joy_sega.sv
// Multi-port Sega Mega Drive pad reader: 8-step select scan plus idle gap,
// 3/6-button and presence detection, optional two-scan debounce.
module joy_sega #(
  parameter int unsigned CH         = 2,
  parameter int unsigned PHASE_CLKS = 500,
  parameter int unsigned IDLE_STEPS = 84,
  parameter int unsigned DEBOUNCE   = 1
) (
  input  logic       clock,
  input  logic       reset,
  joy_sega_if.master bus
);
  localparam int unsigned    PhW       = $clog2(PHASE_CLKS);
  localparam int unsigned    StepMax   = (IDLE_STEPS > 8) ? IDLE_STEPS : 8;
  localparam int unsigned    StW       = $clog2(StepMax);
  localparam logic [PhW-1:0] PhaseLast = PhW'(PHASE_CLKS - 1);
  localparam logic [StW-1:0] IdleLast  = StW'(IDLE_STEPS - 1);
  localparam logic [StW-1:0] ScanLast  = StW'(7);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e              state_q, state_d;
  logic [PhW-1:0]      phase_q, phase_d;
  logic [StW-1:0]      step_q, step_d;
  logic [CH-1:0]       sel_q, sel_d;
  logic [6*CH-1:0]     sync1_q, sync2_q;
  logic [CH-1:0][5:0]  pin;
  logic [CH-1:0][11:0] raw_word_q, raw_word_d;
  logic [CH-1:0]       raw_six_q, raw_six_d;
  logic [CH-1:0]       raw_pres_q, raw_pres_d;
  logic [CH-1:0][13:0] prev_q, prev_d, cand;
  logic [CH-1:0][11:0] joy_q, joy_d;
  logic [CH-1:0]       six_q, six_d;
  logic [CH-1:0]       pres_q, pres_d;
  logic                done_q, done_d;
  logic                step_end;

  // Pins are active-low; 1 here means the pin is pulled low by the pad.
  assign pin      = ~sync2_q;
  assign step_end = (phase_q == PhaseLast);

  // Scan result as compared and committed: {present, six, word}.
  always_comb begin
    cand = '0;
    for (int c = 0; c < CH; c++) begin
      if (raw_pres_q[c]) begin
        cand[c] = {1'b1, raw_six_q[c], raw_six_q[c] ? raw_word_q[c][11:8] : 4'h0,
                   raw_word_q[c][7:0]};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    sel_d      = sel_q;
    phase_d    = step_end ? '0 : phase_q + 1'b1;
    raw_word_d = raw_word_q;
    raw_six_d  = raw_six_q;
    raw_pres_d = raw_pres_q;
    prev_d     = prev_q;
    joy_d      = joy_q;
    six_d      = six_q;
    pres_d     = pres_q;
    done_d     = 1'b0;
    if (step_end) begin
      unique case (state_q)
        StIdle: begin
          sel_d = '1;
          if (step_q == IdleLast) begin
            state_d = StScan;
            step_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        StScan: begin
          // Next step's level: even steps high, odd steps low, idle high.
          sel_d  = {CH{step_q[0]}};
          step_d = step_q + 1'b1;
          for (int c = 0; c < CH; c++) begin
            case (step_q)
              StW'(0): raw_word_d[c] = {4'h0, pin[c][3:0], 1'b0, pin[c][5], 1'b0, pin[c][4]};
              StW'(1): begin
                raw_word_d[c][1] = pin[c][4];
                raw_word_d[c][3] = pin[c][5];
                raw_pres_d[c]    = pin[c][2] & pin[c][3];
              end
              StW'(5): raw_six_d[c] = &pin[c][3:0];
              StW'(6): begin
                if (raw_six_q[c]) begin
                  raw_word_d[c][11:8] = {pin[c][2], pin[c][1], pin[c][0], pin[c][3]};
                end
              end
              default: ;
            endcase
          end
          if (step_q == ScanLast) begin
            state_d = StIdle;
            step_d  = '0;
            done_d  = 1'b1;
            for (int c = 0; c < CH; c++) begin
              if (DEBOUNCE == 0 || cand[c] == prev_q[c]) begin
                {pres_d[c], six_d[c], joy_d[c]} = cand[c];
              end
              prev_d[c] = cand[c];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      step_q     <= '0;
      sel_q      <= '1;
      sync1_q    <= '1;
      sync2_q    <= '1;
      raw_word_q <= '0;
      raw_six_q  <= '0;
      raw_pres_q <= '0;
      prev_q     <= '0;
      joy_q      <= '0;
      six_q      <= '0;
      pres_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      step_q     <= step_d;
      sel_q      <= sel_d;
      sync1_q    <= bus.pad_d;
      sync2_q    <= sync1_q;
      raw_word_q <= raw_word_d;
      raw_six_q  <= raw_six_d;
      raw_pres_q <= raw_pres_d;
      prev_q     <= prev_d;
      joy_q      <= joy_d;
      six_q      <= six_d;
      pres_q     <= pres_d;
      done_q     <= done_d;
    end
  end

  assign bus.pad_sel   = sel_q;
  assign bus.joy       = joy_q;
  assign bus.six_btn   = six_q;
  assign bus.present   = pres_q;
  assign bus.scan_done = done_q;

endmodule

// File: tb/tb_joy_sega.sv
// Bench for joy_sega: behavioural Sega pads on every port, one debounced and one
// undebounced reader sharing the pads, checked against a per-scan result model.
module tb_joy_sega;
  localparam int unsigned CH = 2;
  localparam int unsigned PC = 4;
  localparam int unsigned IS = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  joy_sega_if #(.CH(CH)) bus_db ();
  joy_sega_if #(.CH(CH)) bus_nd ();

  joy_sega #(.CH(CH), .PHASE_CLKS(PC), .IDLE_STEPS(IS), .DEBOUNCE(1)) dut_db (
    .clock(clock), .reset(reset), .bus(bus_db)
  );
  joy_sega #(.CH(CH), .PHASE_CLKS(PC), .IDLE_STEPS(IS), .DEBOUNCE(0)) dut_nd (
    .clock(clock), .reset(reset), .bus(bus_nd)
  );

  // Pad model. ptype: 0 absent, 1 three-button, 2 six-button. btn uses joy bit order.
  int              ptype  [CH];
  logic [11:0]     btn    [CH];
  int              lows   [CH];
  int              hi_cnt [CH];
  logic [CH-1:0]   sel_prev = '1;
  logic [6*CH-1:0] pins;

  // Returns {d9,d6,d4,d3,d2,d1}, active-low. n = select low pulses seen so far.
  function automatic logic [5:0] pad_pins(int ty, logic [11:0] b, logic sel, int n);
    if (ty == 0) return 6'h3F;
    if (sel) begin
      if (ty == 2 && n == 3) return ~{b[2], b[0], b[8], b[11], b[10], b[9]};
      return ~{b[2], b[0], b[7], b[6], b[5], b[4]};
    end
    if (ty == 2 && n == 3) return ~{b[3], b[1], 4'b1111};
    if (ty == 2 && n == 4) return ~{b[3], b[1], 4'b0000};
    return ~{b[3], b[1], 2'b11, b[5], b[4]};
  endfunction

  always_comb begin
    pins = '1;
    for (int c = 0; c < CH; c++) begin
      pins[6*c +: 6] = pad_pins(ptype[c], btn[c], bus_db.pad_sel[c], lows[c]);
    end
  end
  assign bus_db.pad_d = pins;
  assign bus_nd.pad_d = pins;

  // Six-button pads count select pulses and forget them after a long high period.
  always @(posedge clock) begin
    for (int c = 0; c < CH; c++) begin
      if (reset) begin
        lows[c]   <= 0;
        hi_cnt[c] <= 0;
      end else begin
        if (sel_prev[c] && !bus_db.pad_sel[c]) lows[c] <= lows[c] + 1;
        if (bus_db.pad_sel[c]) begin
          hi_cnt[c] <= hi_cnt[c] + 1;
          if (hi_cnt[c] >= 6) lows[c] <= 0;
        end else begin
          hi_cnt[c] <= 0;
        end
      end
    end
    sel_prev <= bus_db.pad_sel;
  end

  // Expected committed {present, six, word} per port for each reader.
  logic [13:0] prev_db [CH];
  logic [13:0] com_db  [CH];
  logic [13:0] com_nd  [CH];

  function automatic logic [13:0] raw_of(int ty, logic [11:0] b);
    if (ty == 1) return {2'b10, 4'h0, b[7:0]};
    if (ty == 2) return {2'b11, b};
    return 14'h0;
  endfunction

  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[4] && b[5]) b[5] = 1'b0;
    if (b[6] && b[7]) b[7] = 1'b0;
    return b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      prev_db[c] = '0;
      com_db[c]  = '0;
      com_nd[c]  = '0;
    end
  endtask

  task automatic model_scan();
    logic [13:0] r;
    for (int c = 0; c < CH; c++) begin
      r         = raw_of(ptype[c], btn[c]);
      com_nd[c] = r;
      if (r == prev_db[c]) com_db[c] = r;
      prev_db[c] = r;
    end
  endtask

  // Advance to the clock after the next scan_done edge (sampled 1 time unit later).
  task automatic wait_scan();
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (bus_db.scan_done !== 1'b1 && n < 200);
    if (bus_db.scan_done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL scan_timeout: scan_done=%b after %0d clocks, required 1", bus_db.scan_done, n);
    end else begin
      model_scan();
    end
  endtask

  task automatic test_reset();
    logic exp_lvl;
    for (int c = 0; c < CH; c++) begin
      ptype[c] = 0;
      btn[c]   = '0;
    end
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    tests++;
    if ({bus_db.pad_sel, bus_db.joy, bus_db.six_btn, bus_db.present, bus_db.scan_done} !==
        {{CH{1'b1}}, {(14*CH+1){1'b0}}}) begin
      fails++;
      $display("FAIL reset_state: sel=%b joy=%h six=%b pres=%b done=%b, required sel=1s rest 0",
               bus_db.pad_sel, bus_db.joy, bus_db.six_btn, bus_db.present, bus_db.scan_done);
    end
    reset = 1'b0;
    model_reset();
    for (int n = 1; n <= 41; n++) begin
      @(posedge clock);
      #1;
      exp_lvl = (n < 8 || n >= 40) ? 1'b1 : (((n - 8) / 4) % 2 == 0);
      tests++;
      if (bus_db.pad_sel !== {CH{exp_lvl}} || bus_nd.pad_sel !== {CH{exp_lvl}}) begin
        fails++;
        $display("FAIL reset_sel clk %0d: got %b/%b required %b", n, bus_db.pad_sel,
                 bus_nd.pad_sel, {CH{exp_lvl}});
      end
      tests++;
      if (bus_db.scan_done !== (n == 40) || bus_nd.scan_done !== (n == 40)) begin
        fails++;
        $display("FAIL reset_done clk %0d: got %b/%b required %b", n, bus_db.scan_done,
                 bus_nd.scan_done, n == 40);
      end
      if (n < 40) begin
        tests++;
        if (bus_db.joy !== '0 || bus_db.present !== '0 || bus_nd.joy !== '0) begin
          fails++;
          $display("FAIL reset_outputs clk %0d: joy=%h pres=%b, required 0", n, bus_db.joy,
                   bus_db.present);
        end
      end
      if (n == 40) model_scan();
    end
  endtask

  task automatic test_three_btn();
    ptype[0] = 1;
    btn[0]   = 12'h012;
    ptype[1] = 0;
    btn[1]   = '0;
    wait_scan();
    tests++;
    if (bus_db.joy[11:0] !== 12'h000 || bus_db.present[0] !== 1'b0) begin
      fails++;
      $display("FAIL three_first_db: joy=%h pres=%b, required 000/0", bus_db.joy[11:0],
               bus_db.present[0]);
    end
    tests++;
    if ({bus_nd.present[0], bus_nd.six_btn[0], bus_nd.joy[11:0]} !== {2'b10, 12'h012}) begin
      fails++;
      $display("FAIL three_first_nd: pres=%b six=%b joy=%h, required 1/0/012",
               bus_nd.present[0], bus_nd.six_btn[0], bus_nd.joy[11:0]);
    end
    wait_scan();
    tests++;
    if (bus_db.joy[11:0] !== 12'h012) begin
      fails++;
      $display("FAIL three_joy: got %h required 012", bus_db.joy[11:0]);
    end
    tests++;
    if (bus_db.six_btn[0] !== 1'b0 || bus_db.present[0] !== 1'b1) begin
      fails++;
      $display("FAIL three_flags: six=%b pres=%b, required 0/1", bus_db.six_btn[0],
               bus_db.present[0]);
    end
  endtask

  task automatic test_six_btn();
    ptype[1] = 2;
    btn[1]   = 12'h908;
    wait_scan();
    wait_scan();
    tests++;
    if (bus_db.joy[23:12] !== 12'h908 || bus_db.six_btn[1] !== 1'b1) begin
      fails++;
      $display("FAIL six_joy: joy=%h six=%b, required 908/1", bus_db.joy[23:12],
               bus_db.six_btn[1]);
    end
    tests++;
    if (bus_db.present[1] !== 1'b1) begin
      fails++;
      $display("FAIL six_present: got %b required 1", bus_db.present[1]);
    end
    tests++;
    if (bus_db.joy[11:0] !== 12'h012 || bus_db.six_btn[0] !== 1'b0) begin
      fails++;
      $display("FAIL six_port0: joy=%h six=%b, required 012/0", bus_db.joy[11:0],
               bus_db.six_btn[0]);
    end
  endtask

  task automatic test_floating();
    for (int c = 0; c < CH; c++) begin
      ptype[c] = 0;
      btn[c]   = 12'hFFF;
    end
    for (int i = 0; i < 3; i++) begin
      wait_scan();
      tests++;
      if (bus_nd.joy !== '0 || bus_nd.six_btn !== '0 || bus_nd.present !== '0) begin
        fails++;
        $display("FAIL float_nd scan %0d: joy=%h six=%b pres=%b, required 0", i, bus_nd.joy,
                 bus_nd.six_btn, bus_nd.present);
      end
      if (i > 0) begin
        tests++;
        if (bus_db.joy !== '0 || bus_db.six_btn !== '0 || bus_db.present !== '0) begin
          fails++;
          $display("FAIL float_db scan %0d: joy=%h six=%b pres=%b, required 0", i,
                   bus_db.joy, bus_db.six_btn, bus_db.present);
        end
      end
    end
  endtask

  task automatic test_glitch();
    ptype[0] = 1;
    btn[0]   = '0;
    ptype[1] = 0;
    btn[1]   = '0;
    wait_scan();
    wait_scan();
    for (int i = 0; i < 4; i++) begin
      btn[0] = (i == 0) ? 12'h001 : 12'h000;
      wait_scan();
      tests++;
      if (bus_db.joy[0] !== 1'b0) begin
        fails++;
        $display("FAIL glitch_db scan %0d: joy[0]=%b required 0", i, bus_db.joy[0]);
      end
      tests++;
      if (bus_nd.joy[0] !== (i == 0)) begin
        fails++;
        $display("FAIL glitch_nd scan %0d: joy[0]=%b required %b", i, bus_nd.joy[0], i == 0);
      end
    end
  endtask

  task automatic test_mid_reset(int s);
    logic exp_lvl;
    ptype[0] = 1;
    btn[0]   = 12'h0A5;
    ptype[1] = 2;
    btn[1]   = 12'h50A;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (8 + 4 * s + 1) @(posedge clock);
    #1;
    tests++;
    if (bus_db.pad_sel !== {CH{s % 2 == 0}}) begin
      fails++;
      $display("FAIL midrst_pos S%0d: sel=%b required %b", s, bus_db.pad_sel, {CH{s % 2 == 0}});
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    tests++;
    if (bus_db.pad_sel !== '1 || bus_db.scan_done !== 1'b0 || bus_db.joy !== '0) begin
      fails++;
      $display("FAIL midrst_abort S%0d: sel=%b done=%b joy=%h, required 1s/0/0", s,
               bus_db.pad_sel, bus_db.scan_done, bus_db.joy);
    end
    reset = 1'b0;
    model_reset();
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      exp_lvl = (n < 8 || n >= 40) ? 1'b1 : (((n - 8) / 4) % 2 == 0);
      tests++;
      if (bus_db.pad_sel !== {CH{exp_lvl}} || bus_db.scan_done !== (n == 40)) begin
        fails++;
        $display("FAIL midrst_rescan S%0d clk %0d: sel=%b done=%b, required %b/%b", s, n,
                 bus_db.pad_sel, bus_db.scan_done, {CH{exp_lvl}}, n == 40);
      end
    end
    model_scan();
    for (int c = 0; c < CH; c++) begin
      tests++;
      if ({bus_nd.present[c], bus_nd.six_btn[c], bus_nd.joy[12*c +: 12]} !== com_nd[c] ||
          {bus_db.present[c], bus_db.six_btn[c], bus_db.joy[12*c +: 12]} !== com_db[c]) begin
        fails++;
        $display("FAIL midrst_result port %0d: nd=%h db=%h, required %h/%h", c,
                 {bus_nd.present[c], bus_nd.six_btn[c], bus_nd.joy[12*c +: 12]},
                 {bus_db.present[c], bus_db.six_btn[c], bus_db.joy[12*c +: 12]},
                 com_nd[c], com_db[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(2, 0) != 0) begin
          ptype[c] = int'($urandom_range(2, 0));
          btn[c]   = rand_btn();
        end
      end
      wait_scan();
      tests++;
      if (bus_nd.scan_done !== 1'b1) begin
        fails++;
        $display("FAIL rand_done_nd scan %0d: got %b required 1", it, bus_nd.scan_done);
      end
      for (int c = 0; c < CH; c++) begin
        tests++;
        if ({bus_db.present[c], bus_db.six_btn[c], bus_db.joy[12*c +: 12]} !== com_db[c]) begin
          fails++;
          $display("FAIL rand_db scan %0d port %0d: got %h required %h", it, c,
                   {bus_db.present[c], bus_db.six_btn[c], bus_db.joy[12*c +: 12]}, com_db[c]);
        end
        tests++;
        if ({bus_nd.present[c], bus_nd.six_btn[c], bus_nd.joy[12*c +: 12]} !== com_nd[c]) begin
          fails++;
          $display("FAIL rand_nd scan %0d port %0d: got %h required %h", it, c,
                   {bus_nd.present[c], bus_nd.six_btn[c], bus_nd.joy[12*c +: 12]}, com_nd[c]);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_three_btn();
    test_six_btn();
    test_floating();
    test_glitch();
    test_mid_reset(4);
    test_mid_reset(5);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/joy_sega.md
# joy_sega

Parametrised multi-port reader for Sega Mega Drive/Genesis pads, the successor to the single-pad joystick scanner. It drives each port's select line through a fixed 8-step scan followed by an idle gap. It auto-detects absent, 3-button and 6-button pads, and debounces the result. It publishes one active-high 12-bit button word per port to the console core, with a commit strobe.

## Interface
- `CH`, 2: number of pad ports scanned in parallel (1..4).
- `PHASE_CLKS`, 500: clocks per scan step (20 µs at 25 MHz); must be ≥ 4.
- `IDLE_STEPS`, 84: steps with select held high after each scan (lets 6-button pads reset their internal counter; must be ≥ 75 at 20 µs/step).
- `DEBOUNCE`, 1: 1 = commit only when two consecutive raw scans agree; 0 = commit every scan.

Ports:
- `clock`  in  1  system clock, 25 MHz.
- `reset`  in  1  synchronous, active-high.
- `pad_d`  in  6*CH  port c pins at [6c+5:6c] = {d9,d6,d4,d3,d2,d1}; asynchronous, active-low, pulled up.
- `pad_sel`  out  CH  select (pin 7) per port, all ports driven identically.
- `joy`  out  12*CH  port c word at [12c+11:12c] = {X,Y,Z,MODE,R,L,D,U,START,C,A,B}; 1 = pressed.
- `six_btn`  out  CH  committed: 6-button pad detected.
- `present`  out  CH  committed: a pad is connected.
- `scan_done`  out  1  one-clock pulse on every scan completion.

## Operation
- Every `pad_d` bit passes a 2-flop synchroniser. All sampling uses the synchronised value, with pins inverted, so 1 = low pin.
- Phase counter runs 0..PHASE_CLKS-1. A step ends on the clock where the counter equals PHASE_CLKS-1. On that edge the pins are sampled, select moves to the next step's level, and the step index advances.
- States: IDLE (sel=1, IDLE_STEPS steps), then S0..S7, then back to IDLE. Reset enters IDLE at step 0.
- Select levels for S0..S7: H,L,H,L,H,L,H,L.
- Samples taken at the end of each step:
  - S0: U=d1, D=d2, L=d3, R=d4, B=d6, C=d9.
  - S1: A=d6, START=d9. Raw present = d3 & d4 (both pins low).
  - S5: raw six = d1 & d2 & d3 & d4.
  - S6, only if raw six: Z=d1, Y=d2, X=d3, MODE=d4.
  - S2, S3, S4 and S7 are not sampled.
- Raw word is forced before compare/commit:
  - raw six=0: bits [11:8] = 0.
  - raw present=0: whole word = 0 and raw six = 0.
- Commit at the end of S7, per port independently:
  - DEBOUNCE=0: `joy`, `six_btn` and `present` load the raw values.
  - DEBOUNCE=1: they load only if the raw {word, six, present} equals the previous scan's raw value; otherwise they hold. The previous-raw register updates every scan.
- `scan_done` pulses every scan regardless of commit outcome.

## Timing
- Reset values:
  - `pad_sel` all 1.
  - `joy`, `six_btn`, `present`, `scan_done` all 0.
  - Previous-raw registers 0.
  - Step and phase counters 0, state IDLE.
- Reset asserted mid-scan aborts the scan on the next edge: select returns high, no commit, and a full IDLE precedes the next scan.
- Scan period is (8+IDLE_STEPS)*PHASE_CLKS clocks; at defaults, 46000 clocks = 1.84 ms.
- Outputs update on the same edge as the S7 sample. `scan_done` is high for exactly the following clock period.
- Input-to-output latency: a level must be stable at least 2 clocks before the sampling edge. It then appears in `joy` at the first S7 commit (DEBOUNCE=0) or the second (DEBOUNCE=1).
- `pad_sel` changes only on step-end edges and is glitch-free (registered).

## Test plan
Benches use PHASE_CLKS=4, IDLE_STEPS=2 and a behavioural pad model.
- Reset held 5 clocks, then released → `pad_sel`=all 1 for 2*4 clocks. S0 starts on the following edge. First `scan_done` comes 40 clocks after release; all outputs are 0 before it.
- 3-button pad on port 0 with A+UP held, DEBOUNCE=1 → after the 2nd `scan_done`, joy[11:0]=12'h012, six_btn[0]=1'b0, present[0]=1'b1. After the 1st scan, outputs are still 0.
- 6-button pad on port 1 with X+MODE+START held → joy[23:12]=12'h908, six_btn[1]=1'b1. Port 0 is unaffected.
- Port left floating (all pins high) → present=0, joy=0, six_btn=0 every scan.
- DEBOUNCE=1, B pressed for exactly one scan window → `joy` never shows bit 0 set. With DEBOUNCE=0, the same stimulus gives joy[0]=1 for exactly one commit period.
- Reset asserted during S4 → `pad_sel` is 1 on the next edge, no `scan_done` for that scan, and the next scan is preceded by 8 high clocks.
